// File: rtl/hist_otsu_thresh_pkg.sv
// Shared definitions for the Otsu threshold block: FSM encoding, default
// geometry and the accumulator widths derived from the bin-count width.
package hist_otsu_thresh_pkg;

    localparam int unsigned BINS_DEF        = 256;
    localparam int unsigned COUNT_WIDTH_DEF = 24;
    localparam int unsigned ADDR_W          = 8;

    // N holds a sum of up to 256 counts; S additionally carries an 8-bit bin weight.
    localparam int unsigned N_W = COUNT_WIDTH_DEF + 8;
    localparam int unsigned S_W = COUNT_WIDTH_DEF + 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int unsigned n_w(input int unsigned count_width);
        return count_width + 8;
    endfunction

    function automatic int unsigned s_w(input int unsigned count_width);
        return count_width + 16;
    endfunction

endpackage

// File: rtl/hist_otsu_thresh_otsu_cmp.sv
// Division-free comparator for Otsu between-class variance num/den ratios.
// Ports: have_best (a best candidate exists), num_c/den_c (candidate),
//        num_b/den_b (current best), replace_c (candidate strictly better).
module otsu_cmp #(
    parameter int unsigned NUM_W = 144,
    parameter int unsigned DEN_W = 64
) (
    input  logic             have_best,
    input  logic [NUM_W-1:0] num_c,
    input  logic [DEN_W-1:0] den_c,
    input  logic [NUM_W-1:0] num_b,
    input  logic [DEN_W-1:0] den_b,
    output logic             replace_c
);

    localparam int unsigned X_W = NUM_W + DEN_W;

    logic [X_W-1:0] lhs;
    logic [X_W-1:0] rhs;

    // Cross-multiplied ratios; strict compare so equal ratios keep the lower t.
    assign lhs       = X_W'(num_c) * X_W'(den_b);
    assign rhs       = X_W'(num_b) * X_W'(den_c);
    assign replace_c = !have_best || (lhs > rhs);

endmodule

// File: rtl/hist_otsu_thresh.sv
// Otsu threshold engine over an external histogram memory.
// Two passes over the bins: SUM totals N and S, SCAN evaluates every
// candidate threshold and keeps the best; DONE publishes the result.
// Ports: clk, rst_n, start (pulse), busy, done (pulse), hist_rd_addr /
//        hist_rd_data (1-cycle read latency), threshold, degenerate.
module hist_otsu_thresh
    import hist_otsu_thresh_pkg::*;
#(
    parameter int unsigned BINS        = BINS_DEF,
    parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             hist_rd_addr,
    input  logic [COUNT_WIDTH-1:0] hist_rd_data,
    output logic [7:0]             threshold,
    output logic                   degenerate
);

    localparam int unsigned NW    = n_w(COUNT_WIDTH);
    localparam int unsigned SW    = s_w(COUNT_WIDTH);
    localparam int unsigned PW    = NW + SW;
    localparam int unsigned DW    = PW + 1;
    localparam int unsigned NUMW  = 2 * PW;
    localparam int unsigned DENW  = 2 * NW;
    localparam int unsigned CNT_W = $clog2(BINS + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        addr_q, addr_d;
    logic [NW-1:0]     n_q, n_d;
    logic [SW-1:0]     s_q, s_d;
    logic [NW-1:0]     w0_q, w0_d;
    logic [SW-1:0]     sum0_q, sum0_d;
    logic [NUMW-1:0]   best_num_q, best_num_d;
    logic [DENW-1:0]   best_den_q, best_den_d;
    logic [7:0]        best_t_q, best_t_d;
    logic              have_best_q, have_best_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        thr_q, thr_d;
    logic              deg_q, deg_d;

    logic [7:0]        bin_t;
    logic [SW-1:0]     tprod;
    logic [NW-1:0]     w0_new;
    logic [SW-1:0]     sum0_new;
    logic [PW-1:0]     prod_a;
    logic [PW-1:0]     prod_b;
    logic signed [DW-1:0] diff;
    logic [PW-1:0]     mag;
    logic [NUMW-1:0]   num_c;
    logic [DENW-1:0]   den_c;
    logic              valid_c;
    logic              replace_c;

    // Candidate datapath; data in cycle cnt belongs to bin cnt-1.
    always_comb begin
        bin_t    = 8'(cnt_q - CNT_W'(1));
        tprod    = SW'(bin_t) * SW'(hist_rd_data);
        w0_new   = w0_q + NW'(hist_rd_data);
        sum0_new = sum0_q + tprod;
        prod_a   = PW'(n_q) * PW'(sum0_new);
        prod_b   = PW'(w0_new) * PW'(s_q);
        diff     = $signed({1'b0, prod_a}) - $signed({1'b0, prod_b});
        mag      = diff[DW-1] ? PW'(-diff) : PW'(diff);
        num_c    = NUMW'(mag) * NUMW'(mag);
        den_c    = DENW'(w0_new) * DENW'(n_q - w0_new);
        valid_c  = (w0_new != '0) && (w0_new < n_q);
    end

    otsu_cmp #(
        .NUM_W (NUMW),
        .DEN_W (DENW)
    ) u_cmp (
        .have_best (have_best_q),
        .num_c     (num_c),
        .den_c     (den_c),
        .num_b     (best_num_q),
        .den_b     (best_den_q),
        .replace_c (replace_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        n_d         = n_q;
        s_d         = s_q;
        w0_d        = w0_q;
        sum0_d      = sum0_q;
        best_num_d  = best_num_q;
        best_den_d  = best_den_q;
        best_t_d    = best_t_q;
        have_best_d = have_best_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        thr_d       = thr_q;
        deg_d       = deg_q;

        case (state_q)
            ST_IDLE: begin
                addr_d = 8'd0;
                if (start) begin
                    state_d     = ST_SUM;
                    cnt_d       = '0;
                    n_d         = '0;
                    s_d         = '0;
                    w0_d        = '0;
                    sum0_d      = '0;
                    best_num_d  = '0;
                    best_den_d  = '0;
                    best_t_d    = 8'd0;
                    have_best_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_SUM, ST_SCAN: begin
                cnt_d  = cnt_q + CNT_W'(1);
                addr_d = (cnt_q < CNT_W'(BINS - 1)) ? 8'(cnt_q + CNT_W'(1)) : 8'd0;
                if (cnt_q != '0) begin
                    if (state_q == ST_SUM) begin
                        n_d = n_q + NW'(hist_rd_data);
                        s_d = s_q + tprod;
                    end else begin
                        w0_d   = w0_new;
                        sum0_d = sum0_new;
                        if (valid_c && replace_c) begin
                            best_num_d  = num_c;
                            best_den_d  = den_c;
                            best_t_d    = bin_t;
                            have_best_d = 1'b1;
                        end
                    end
                end
                if (cnt_q == CNT_W'(BINS)) begin
                    state_d = (state_q == ST_SUM) ? ST_SCAN : ST_DONE;
                    cnt_d   = '0;
                    addr_d  = 8'd0;
                end
            end
            ST_DONE: begin
                addr_d  = 8'd0;
                thr_d   = have_best_q ? best_t_q : 8'd0;
                deg_d   = !have_best_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 8'd0;
            n_q         <= '0;
            s_q         <= '0;
            w0_q        <= '0;
            sum0_q      <= '0;
            best_num_q  <= '0;
            best_den_q  <= '0;
            best_t_q    <= 8'd0;
            have_best_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            thr_q       <= 8'd0;
            deg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            s_q         <= s_d;
            w0_q        <= w0_d;
            sum0_q      <= sum0_d;
            best_num_q  <= best_num_d;
            best_den_q  <= best_den_d;
            best_t_q    <= best_t_d;
            have_best_q <= have_best_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            thr_q       <= thr_d;
            deg_q       <= deg_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign hist_rd_addr = addr_q;
    assign threshold    = thr_q;
    assign degenerate   = deg_q;

endmodule

// File: tb/tb_hist_otsu_thresh.sv
// Directed and randomised checks of hist_otsu_thresh against hand-computed
// results and a floating-point Otsu reference.
module tb_hist_otsu_thresh;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  hist_rd_addr;
    logic [23:0] hist_rd_data;
    logic [7:0]  threshold;
    logic        degenerate;

    logic [23:0] hist [256];

    int checks;
    int failures;

    hist_otsu_thresh dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data),
        .threshold    (threshold),
        .degenerate   (degenerate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Histogram memory with one cycle of read latency.
    always @(posedge clk) hist_rd_data <= hist[hist_rd_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 256; i++) hist[i] = 24'd0;
    endtask

    // Floating-point Otsu: maximise w0*w1*(mu0-mu1)^2, lowest t wins ties.
    task automatic otsu_ref(output int thr, output bit deg);
        real n, s, w0, sum0, w1, mu0, mu1, v, best;
        n = 0.0; s = 0.0; w0 = 0.0; sum0 = 0.0; best = 0.0;
        thr = 0; deg = 1'b1;
        for (int i = 0; i < 256; i++) begin
            n = n + real'(hist[i]);
            s = s + real'(i) * real'(hist[i]);
        end
        for (int t = 0; t < 256; t++) begin
            w0   = w0 + real'(hist[t]);
            sum0 = sum0 + real'(t) * real'(hist[t]);
            if (w0 > 0.0 && w0 < n) begin
                w1  = n - w0;
                mu0 = sum0 / w0;
                mu1 = (s - sum0) / w1;
                v   = w0 * w1 * (mu0 - mu1) * (mu0 - mu1);
                if (deg || v > best * (1.0 + 1e-9)) begin
                    best = v;
                    thr  = t;
                    deg  = 1'b0;
                end
            end
        end
    endtask

    // One computation: pulse start, optionally re-pulse at cycle repulse_at,
    // measure the start-to-done latency and check the result.
    task automatic run(input string name, input int repulse_at, input int exp_thr, input bit exp_deg);
        int lat;
        lat = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
        for (int c = 1; c <= 1200 && lat < 0; c++) begin
            start = (c == repulse_at);
            @(posedge clk);
            #1;
            if (done) lat = c;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(lat), 64'd515);
        check({name, "_thr"}, 64'(threshold), 64'(exp_thr));
        check({name, "_deg"}, 64'(degenerate), 64'(exp_deg));
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        check({name, "_addr_idle"}, 64'(hist_rd_addr), 64'd0);
        check({name, "_thr_hold"}, 64'(threshold), 64'(exp_thr));
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
    endtask

    initial begin
        int n_done;
        int r_thr;
        bit r_deg;
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        rst_n    = 1'b1;
        clear_hist();
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_thr", 64'(threshold), 64'd0);
        check("rst_deg", 64'(degenerate), 64'd0);
        check("rst_addr", 64'(hist_rd_addr), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Three single pixels: best split between 20 and 200.
        hist[10] = 24'd1; hist[20] = 24'd1; hist[200] = 24'd1;
        run("three_px", 0, 20, 1'b0);

        // Two equal clusters: every t in 50..199 ties, lowest wins.
        clear_hist();
        hist[50] = 24'd100; hist[200] = 24'd100;
        run("two_clusters", 0, 50, 1'b0);

        clear_hist();
        run("empty", 0, 0, 1'b1);

        hist[128] = 24'd10;
        run("single_bin", 0, 0, 1'b1);

        // Full-scale counts at both ends.
        clear_hist();
        hist[0] = 24'hFFFFFF; hist[255] = 24'hFFFFFF;
        run("full_scale", 0, 0, 1'b0);

        // Start re-pulsed during SCAN is ignored.
        clear_hist();
        hist[10] = 24'd1; hist[20] = 24'd1; hist[200] = 24'd1;
        run("repulse", 300, 20, 1'b0);
        count_dones(600, n_done);
        check("repulse_extra_done", 64'(n_done), 64'd0);

        // Reset in the middle of SUM aborts without done.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_thr", 64'(threshold), 64'd0);
        check("abort_deg", 64'(degenerate), 64'd0);
        check("abort_addr", 64'(hist_rd_addr), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        count_dones(600, n_done);
        check("abort_no_done", 64'(n_done), 64'd0);
        clear_hist();
        hist[50] = 24'd100; hist[200] = 24'd100;
        run("after_abort", 0, 50, 1'b0);

        // Random histograms against the floating-point reference.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 256; i++)
                hist[i] = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 1000)) : 24'd0;
            otsu_ref(r_thr, r_deg);
            run($sformatf("rand%0d", k), 0, r_thr, r_deg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
